pi_ratio_bcd_engine: RTL and testbench

PI_RATIO_BCD_ENGINE -- requirements
Module: pi_ratio_bcd_engine

---
 rtl/pi_ratio_bcd_engine.sv | 184 ++++++++++++++++++
 tb/tb_pi_ratio_bcd_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_ratio_bcd_engine.sv
// ---------------------------------------------------------------------------
// PiRatioBcdEngine -- pi_ratio_bcd_engine
//
// Purpose:
//   Turns a pair of Monte-Carlo hit counters into a decimal estimate of
//   4*circle_cnt/square_cnt. The estimate is one BCD integer digit plus
//   N_FRAC BCD fractional digits. It is built by restoring long division:
//   one subtraction per clock, and one clock to store each digit. The result
//   is truncated. It saturates to 9.99..9 when the integer part would exceed
//   9. The published outputs only change on the commit cycle, so a display
//   that reads them mid-computation still sees the previous estimate.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (priority over start)
//   start        request a new estimate; only honoured while idle
//   circle_cnt   hits inside the circle, sampled on the accepted start
//   square_cnt   hits inside the square, sampled on the accepted start
//   busy         high from the cycle after an accepted start through commit
//   done         one-cycle pulse once the outputs hold the new estimate
//   int_digit    BCD integer digit
//   frac_digits  BCD fractional digits, first digit after the point in MSBs
//   ovf          last estimate saturated (integer part above 9)
//   div0         last estimate had square_cnt == 0
// ---------------------------------------------------------------------------
module pi_ratio_bcd_engine #(
  parameter int N_FRAC = 5,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    circle_cnt,
  input  logic [CNT_W-1:0]    square_cnt,
  output logic                busy,
  output logic                done,
  output logic [3:0]          int_digit,
  output logic [4*N_FRAC-1:0] frac_digits,
  output logic                ovf,
  output logic                div0
);

  // The remainder carries two extra bits for the initial 4*circle_cnt. It
  // carries two more bits so that rem*10 fits: after the integer digit,
  // rem < divisor < 2^CNT_W always holds.
  localparam int R_W   = CNT_W + 4;
  localparam int IDX_W = $clog2(N_FRAC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FRAC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]    divisor;
  logic [R_W-1:0]      rem;
  logic [3:0]          q;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          work_int;
  logic [4*N_FRAC-1:0] work_frac;
  logic                work_ovf;
  logic                work_div0;

  logic [R_W-1:0]      divisor_ext;
  logic [R_W-1:0]      rem_x10;
  logic                rem_ge;
  logic                saturate;

  assign divisor_ext = {4'b0000, divisor};
  assign rem_x10     = (rem << 3) + (rem << 1);
  assign rem_ge      = (rem >= divisor_ext);
  // A tenth subtraction would be needed. This can only happen on the
  // integer digit, because every later digit starts from rem < divisor.
  assign saturate    = rem_ge && (q == 4'd9);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and busy decode.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (square_cnt == '0) ? COMMIT : DIV;
        end
      end
      DIV: begin
        busy = 1'b1;
        if (saturate) begin
          state_next = COMMIT;
        end else if (!rem_ge && (idx == LAST_IDX)) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Division datapath, working digit registers and published outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor     <= '0;
      rem         <= '0;
      q           <= '0;
      idx         <= '0;
      work_int    <= '0;
      work_frac   <= '0;
      work_ovf    <= 1'b0;
      work_div0   <= 1'b0;
      done        <= 1'b0;
      int_digit   <= '0;
      frac_digits <= '0;
      ovf         <= 1'b0;
      div0        <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (start) begin
            divisor   <= square_cnt;
            rem       <= {2'b00, circle_cnt, 2'b00};
            q         <= '0;
            idx       <= '0;
            work_int  <= '0;
            work_frac <= '0;
            work_ovf  <= 1'b0;
            work_div0 <= (square_cnt == '0);
          end
        end
        DIV: begin
          if (saturate) begin
            work_ovf  <= 1'b1;
            work_int  <= 4'd9;
            work_frac <= {N_FRAC{4'd9}};
          end else if (rem_ge) begin
            rem <= rem - divisor_ext;
            q   <= q + 4'd1;
          end else begin
            if (idx == '0) begin
              work_int <= q;
            end
            // Fractional digit idx lands in nibble N_FRAC-idx. This keeps
            // the first digit after the point in the top nibble.
            for (int i = 0; i < N_FRAC; i++) begin
              if (idx == IDX_W'(i + 1)) begin
                work_frac[4*(N_FRAC-1-i) +: 4] <= q;
              end
            end
            rem <= rem_x10;
            q   <= '0;
            idx <= idx + IDX_W'(1);
          end
        end
        COMMIT: begin
          int_digit   <= work_int;
          frac_digits <= work_frac;
          ovf         <= work_ovf;
          div0        <= work_div0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_ratio_bcd_engine.sv
// ---------------------------------------------------------------------------
// tb_pi_ratio_bcd_engine
//
// Purpose:
//   Self-checking bench for pi_ratio_bcd_engine with N_FRAC=5, CNT_W=32.
//   A table of vectors holds hand-derived results. Each vector is started in
//   turn, and its expected result goes into a scoreboard queue. A monitor
//   pops the queue on every done pulse. It compares the digits, the flags,
//   and the latency measured from the start cycle. Hand-written sequences
//   cover reset, a start while busy, and a reset in the middle of a division.
//
// Latency = sum over digits of (digit+1) + 2. A saturated estimate needs 10
// division cycles, so its latency is 12.
// ---------------------------------------------------------------------------
module tb_pi_ratio_bcd_engine;

  localparam int N_FRAC = 5;
  localparam int CNT_W  = 32;
  localparam int NVEC   = 13;

  typedef struct {
    logic [31:0] circle;
    logic [31:0] square;
    logic [3:0]  exp_int;
    logic [19:0] exp_frac;
    logic        exp_ovf;
    logic        exp_div0;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0]  exp_int;
    logic [19:0] exp_frac;
    logic        exp_ovf;
    logic        exp_div0;
    int          exp_lat;
    int          start_cyc;
  } exp_t;

  logic                clk;
  logic                reset;
  logic                start;
  logic [CNT_W-1:0]    circle_cnt;
  logic [CNT_W-1:0]    square_cnt;
  logic                busy;
  logic                done;
  logic [3:0]          int_digit;
  logic [4*N_FRAC-1:0] frac_digits;
  logic                ovf;
  logic                div0;

  int   n_checks;
  int   n_pass;
  int   cyc;
  int   done_count;
  exp_t sb[$];
  vec_t vecs[NVEC];

  pi_ratio_bcd_engine #(
    .N_FRAC(N_FRAC),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .circle_cnt (circle_cnt),
    .square_cnt (square_cnt),
    .busy       (busy),
    .done       (done),
    .int_digit  (int_digit),
    .frac_digits(frac_digits),
    .ovf        (ovf),
    .div0       (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges so the monitor can measure latency in cycles.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      n_pass++;
    end
  endtask

  // Drives one start cycle and pushes its expected result.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    circle_cnt = v.circle;
    square_cnt = v.square;
    e.exp_int   = v.exp_int;
    e.exp_frac  = v.exp_frac;
    e.exp_ovf   = v.exp_ovf;
    e.exp_div0  = v.exp_div0;
    e.exp_lat   = v.exp_lat;
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start pulse with no expected result, for requests that must be dropped.
  task automatic pulseStart(input logic [31:0] c, input logic [31:0] s);
    @(negedge clk);
    start      = 1'b1;
    circle_cnt = c;
    square_cnt = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL drain_timeout: %0d results pending after %0d cycles, expected 0",
               sb.size(), budget);
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("int_digit", 32'(int_digit), 32'(e.exp_int));
        checkOutput("frac_digits", 32'(frac_digits), 32'(e.exp_frac));
        checkOutput("ovf", 32'(ovf), 32'(e.exp_ovf));
        checkOutput("div0", 32'(div0), 32'(e.exp_div0));
        checkOutput("latency", 32'(cyc - e.start_cyc), 32'(e.exp_lat));
      end
    end
  end

  initial begin
    int dc0;
    vec_t v;

    n_checks   = 0;
    n_pass     = 0;
    done_count = 0;

    //          circle        square        int   frac      ovf   div0  lat
    vecs[0]  = '{32'd1,        32'd1,        4'd4, 20'h00000, 1'b0, 1'b0, 12};
    vecs[1]  = '{32'd785398,   32'd1000000,  4'd3, 20'h14159, 1'b0, 1'b0, 31};
    vecs[2]  = '{32'd3,        32'd1,        4'd9, 20'h99999, 1'b1, 1'b0, 12};
    vecs[3]  = '{32'd1,        32'd1,        4'd4, 20'h00000, 1'b0, 1'b0, 12};
    vecs[4]  = '{32'd5,        32'd0,        4'd0, 20'h00000, 1'b0, 1'b1, 2};
    vecs[5]  = '{32'd1,        32'd3,        4'd1, 20'h33333, 1'b0, 1'b0, 24};
    vecs[6]  = '{32'd5,        32'd2,        4'd9, 20'h99999, 1'b1, 1'b0, 12};
    vecs[7]  = '{32'd9,        32'd4,        4'd9, 20'h00000, 1'b0, 1'b0, 17};
    vecs[8]  = '{32'd0,        32'd7,        4'd0, 20'h00000, 1'b0, 1'b0, 8};
    vecs[9]  = '{32'd1,        32'd7,        4'd0, 20'h57142, 1'b0, 1'b0, 27};
    vecs[10] = '{32'd10,       32'd4,        4'd9, 20'h99999, 1'b1, 1'b0, 12};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 20'h00000, 1'b0, 1'b0, 12};
    vecs[12] = '{32'd1,        32'hFFFFFFFF, 4'd0, 20'h00000, 1'b0, 1'b0, 8};

    // Reset with start held high: reset wins and everything reads zero.
    reset      = 1'b1;
    start      = 1'b1;
    circle_cnt = 32'd1;
    square_cnt = 32'd1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_int", 32'(int_digit), 32'd0);
    checkOutput("reset_frac", 32'(frac_digits), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_div0", 32'(div0), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset_busy", 32'(busy), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      waitDrain(150);
    end

    // Start while busy: the second request is dropped, giving one done only.
    dc0 = done_count;
    v = '{32'd1, 32'd3, 4'd1, 20'h33333, 1'b0, 1'b0, 24};
    applyStimulus(v);
    repeat (3) @(negedge clk);
    checkOutput("busy_mid_div", 32'(busy), 32'd1);
    checkOutput("stable_int_mid_div", 32'(int_digit), 32'd0);
    checkOutput("stable_frac_mid_div", 32'(frac_digits), 32'h00000);
    pulseStart(32'd3, 32'd1);
    checkOutput("busy_after_ignored_start", 32'(busy), 32'd1);
    waitDrain(150);
    repeat (30) @(negedge clk);
    checkOutput("single_done_pulse", 32'(done_count - dc0), 32'd1);
    checkOutput("ignored_start_no_ovf", 32'(ovf), 32'd0);

    // Reset during DIV: the old result is wiped, no done, and a restart works.
    v = '{32'd1, 32'd7, 4'd0, 20'h57142, 1'b0, 1'b0, 27};
    applyStimulus(v);
    waitDrain(150);
    pulseStart(32'd785398, 32'd1000000);
    repeat (5) @(negedge clk);
    checkOutput("busy_before_abort", 32'(busy), 32'd1);
    checkOutput("stable_frac_before_abort", 32'(frac_digits), 32'h57142);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_int", 32'(int_digit), 32'd0);
    checkOutput("abort_frac", 32'(frac_digits), 32'd0);
    dc0 = done_count;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_count - dc0), 32'd0);
    v = '{32'd1, 32'd1, 4'd4, 20'h00000, 1'b0, 1'b0, 12};
    applyStimulus(v);
    waitDrain(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
